approx_add_stream: RTL and testbench
====================================

Name: approx_add_stream

Overview:
- Streaming, parametrised successor to the 8-bit approximate adder used for image blending.
- Adds two pixel streams (A, B) with a lower-part-OR approximate adder (LOA) of configurable approximate width.
- Exact/approximate and wrap/saturate modes are selectable per beat; valid/ready handshakes on both sides.
- Counts pixels per frame and accumulates per-frame absolute error against the exact sum, so the bench reads quality metrics directly instead of post-processing files.

Parameters:
- DATA_W, 8, pixel/operand width in bits (>=2).
- APPROX_BITS, 4, number of LSBs computed approximately (0..DATA_W-1); 0 means always exact.
- FRAME_PIXELS, 262144, beats per frame (512*512); must be >=1.
- CNT_W, 18, pixel counter width; must satisfy 2^CNT_W >= FRAME_PIXELS.
- ERR_W, 32, error accumulator width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- mode_approx  in  1  1 = LOA arithmetic, 0 = exact; sampled with the beat.
- mode_sat  in  1  1 = saturate on carry-out, 0 = wrap; sampled with the beat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  DATA_W  result.
- out_carry  out  1  raw carry-out of the selected adder, before saturation.
- out_eof  out  1  high on the last beat of a frame, qualified by out_valid.
- err_frame  out  ERR_W  total absolute error of the last completed frame.
- frame_done  out  1  one-cycle pulse when err_frame updates.

Behaviour:
- Reset (asynchronous assert, released on clk): in_ready=1, out_valid=0, out_sum=0, out_carry=0, out_eof=0, err_frame=0, frame_done=0. Pixel counter=0, err_acc=0. Pipeline valid bits cleared; in-flight beats are discarded.
- Input handshake: a beat is accepted when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Pipeline, two stages:
  - S1 registers operands and modes.
  - S2 registers the result and the beat's error.
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_load.
  - Latency is 2 cycles from acceptance to out_valid with no stall. Throughput is 1 beat/cycle. No beat is lost or duplicated under any out_ready pattern.
- Output stability: out_sum, out_carry and out_eof hold stable while out_valid && !out_ready.
- Arithmetic, with K=APPROX_BITS:
  - Exact: {c, s} = a + b, DATA_W+1 bits.
  - LOA, K>0:
    - s[K-1:0] = a[K-1:0] | b[K-1:0].
    - cin = a[K-1] & b[K-1].
    - {c, s[DATA_W-1:K]} = a[DATA_W-1:K] + b[DATA_W-1:K] + cin.
  - When K=0 or mode_approx=0, the exact adder is used.
  - Saturation: if mode_sat && c, then out_sum = all ones; otherwise out_sum = s.
- Error per beat: e = |(exact {c,s}) - (selected {c,s})|, DATA_W+1 bits, computed before saturation. e=0 in exact mode.
- Error accumulation: err_acc += e on each output transfer, saturating at 2^ERR_W-1.
- Frame counter: increments on each output transfer.
  - out_eof = 1 when counter == FRAME_PIXELS-1.
  - On the transfer with out_eof: err_frame <= err_acc + e (saturating), frame_done pulses the next cycle, counter wraps to 0, err_acc <= 0.
  - FRAME_PIXELS=1: every beat is eof.
- Mode changes between beats are legal and take effect per beat. In-flight beats keep the modes they were sampled with.
- Reset mid-frame: counter and err_acc return to 0; err_frame returns to 0.

Decomposition:
- Shared package approx_pkg: mode encoding constants (MODE_EXACT, MODE_LOA), default widths (PIX_W=8, FRAME_512=262144).
- One sub-module, loa_adder: purely combinational, parametrised DATA_W/APPROX_BITS. Outputs exact sum, approximate sum, both carries and abs error. Reused by future multi-channel wrappers.
- Top handles the pipeline, handshake and counters.

Test Plan:
- Defaults, mode_approx=1, mode_sat=0, a=0x1F, b=0x01 -> out_sum=0x1F, out_carry=0, e=1. Exact mode, same operands -> out_sum=0x20, e=0.
- a=0xF0, b=0x20, exact -> wrap gives out_sum=0x10, out_carry=1. mode_sat=1 gives out_sum=0xFF, out_carry=1.
- in_valid held high with incrementing data; out_ready low 5 cycles then high -> in_ready drops after 2 beats accepted. Outputs appear in order with no loss or duplication; out_sum stays stable while stalled.
- FRAME_PIXELS=4, four LOA beats of 0x1F+0x01 -> out_eof on 4th transfer; frame_done pulses once; err_frame=4; next frame restarts at count 0.
- rst asserted mid-frame with both stages full -> out_valid=0 and in_ready=1 immediately (asynchronous). err_frame=0. The next frame's eof arrives after exactly FRAME_PIXELS transfers.
- APPROX_BITS=0, random 1000 beats with mode_approx=1 -> results equal exact sum; err_frame=0.

Source files
------------

// File: rtl/approx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : approx_pkg
// Purpose  : Shared mode encodings, default widths and beat-mode struct for
//            the approximate-adder stream family.
// Revision : 1.0 - initial release
// ============================================================================
package approx_pkg;

  // Arithmetic mode encoding carried with each beat
  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LOA   = 1'b1;

  // Default pixel width and 512x512 frame size
  localparam int PIX_W     = 8;
  localparam int FRAME_512 = 262144;

  // Per-beat mode bits, captured together with the operands
  typedef struct packed {
    logic approx;
    logic sat;
  } mode_t;

endpackage
`default_nettype wire

// File: rtl/loa_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : loa_adder
// Purpose  : Combinational lower-part-OR adder. Produces the exact sum, the
//            LOA sum, both carries and the absolute error between them.
// Revision : 1.0 - initial release
// ============================================================================
module loa_adder #(
  parameter int DATA_W      = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] exact_sum,
  output logic              exact_carry,
  output logic [DATA_W-1:0] approx_sum,
  output logic              approx_carry,
  output logic [DATA_W:0]   abs_err
);

  localparam int K = APPROX_BITS;

  logic [DATA_W:0] exact_full;
  logic [DATA_W:0] approx_full;

  assign {exact_carry, exact_sum} = {1'b0, a} + {1'b0, b};

  generate
    if (K > 0) begin : g_loa
      localparam int HI_W = DATA_W - K;
      logic            cin;
      logic [HI_W:0]   hi;
      // The top OR'd bit pair predicts the carry into the exact upper part
      assign cin          = a[K-1] & b[K-1];
      assign hi           = {1'b0, a[DATA_W-1:K]} + {1'b0, b[DATA_W-1:K]} + {{HI_W{1'b0}}, cin};
      assign approx_sum   = {hi[HI_W-1:0], a[K-1:0] | b[K-1:0]};
      assign approx_carry = hi[HI_W];
    end else begin : g_exact
      assign approx_sum   = exact_sum;
      assign approx_carry = exact_carry;
    end
  endgenerate

  assign exact_full  = {exact_carry, exact_sum};
  assign approx_full = {approx_carry, approx_sum};

  // LOA can over- or under-estimate, so take the magnitude of the difference
  always_comb begin
    abs_err = '0;
    if (exact_full >= approx_full) abs_err = exact_full - approx_full;
    else                           abs_err = approx_full - exact_full;
  end

endmodule
`default_nettype wire

// File: rtl/approx_add_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : approx_add_stream
// Purpose  : Two-stage valid/ready stream adder with per-beat exact/LOA and
//            wrap/saturate modes, frame counting and per-frame error totals.
// Revision : 1.0 - initial release
// ============================================================================
module approx_add_stream
  import approx_pkg::*;
#(
  parameter int DATA_W       = PIX_W,
  parameter int APPROX_BITS  = 4,
  parameter int FRAME_PIXELS = FRAME_512,
  parameter int CNT_W        = 18,
  parameter int ERR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              mode_approx,
  input  logic              mode_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_carry,
  output logic              out_eof,
  output logic [ERR_W-1:0]  err_frame,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

  // Stage 1: operands and modes
  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  mode_t             s1_mode;

  // Stage 2: result and beat error
  logic              s2_valid;
  logic [DATA_W-1:0] s2_sum;
  logic              s2_carry;
  logic [DATA_W:0]   s2_err;

  // Frame bookkeeping
  logic [CNT_W-1:0]  pix_cnt;
  logic [ERR_W-1:0]  err_acc;
  logic [ERR_W-1:0]  err_frame_q;
  logic              frame_done_q;

  logic              s2_load;
  logic              out_xfer;
  logic              last_beat;

  // Adder results for the beat sitting in stage 1
  logic [DATA_W-1:0] ex_sum;
  logic              ex_carry;
  logic [DATA_W-1:0] ap_sum;
  logic              ap_carry;
  logic [DATA_W:0]   ap_err;
  logic              use_loa;
  logic [DATA_W-1:0] sel_sum;
  logic              sel_carry;
  logic [DATA_W:0]   beat_err;
  logic [DATA_W-1:0] res_sum;

  logic [ERR_W:0]    acc_wide;
  logic [ERR_W-1:0]  acc_next;

  loa_adder #(
    .DATA_W      (DATA_W),
    .APPROX_BITS (APPROX_BITS)
  ) u_loa (
    .a            (s1_a),
    .b            (s1_b),
    .exact_sum    (ex_sum),
    .exact_carry  (ex_carry),
    .approx_sum   (ap_sum),
    .approx_carry (ap_carry),
    .abs_err      (ap_err)
  );

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign out_xfer  = s2_valid && out_ready;
  assign last_beat = (pix_cnt == LAST_CNT);

  // With APPROX_BITS=0 the adder's LOA outputs already equal the exact ones
  assign use_loa   = (s1_mode.approx == MODE_LOA);
  assign sel_sum   = use_loa ? ap_sum   : ex_sum;
  assign sel_carry = use_loa ? ap_carry : ex_carry;
  assign beat_err  = use_loa ? ap_err   : '0;
  assign res_sum   = (s1_mode.sat && sel_carry) ? '1 : sel_sum;

  // Error accumulation saturates instead of wrapping
  assign acc_wide  = {1'b0, err_acc} + (ERR_W+1)'(s2_err);
  assign acc_next  = acc_wide[ERR_W] ? '1 : acc_wide[ERR_W-1:0];

  assign out_valid  = s2_valid;
  assign out_sum    = s2_sum;
  assign out_carry  = s2_carry;
  assign out_eof    = s2_valid && last_beat;
  assign err_frame  = err_frame_q;
  assign frame_done = frame_done_q;

  // Stage 1: capture a beat whenever there is room for it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '{approx: MODE_EXACT, sat: 1'b0};
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= '{approx: mode_approx, sat: mode_sat};
      end
    end
  end

  // Stage 2: register result; hold it while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= 1'b0;
      s2_err   <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_sum   <= res_sum;
      s2_carry <= sel_carry;
      s2_err   <= beat_err;
    end else if (out_xfer) begin
      s2_valid <= 1'b0;
    end
  end

  // Frame counter, error accumulator and per-frame error publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt      <= '0;
      err_acc      <= '0;
      err_frame_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_xfer && last_beat;
      if (out_xfer) begin
        if (last_beat) begin
          pix_cnt     <= '0;
          err_acc     <= '0;
          err_frame_q <= acc_next;
        end else begin
          pix_cnt     <= pix_cnt + CNT_W'(1);
          err_acc     <= acc_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_approx_add_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_approx_add_stream
// Purpose  : Directed self-checking bench: LOA/exact arithmetic, saturation,
//            back-pressure, frame error totals, async reset, exact-only build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_add_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT 0: 8-bit, 4 approximate bits, 4-pixel frames
  logic       in_valid, in_ready, mode_approx, mode_sat;
  logic       out_valid, out_ready, out_carry, out_eof, frame_done;
  logic [7:0] in_a, in_b, out_sum;
  logic [31:0] err_frame;

  // DUT 1: exact-only build (APPROX_BITS=0)
  logic       in_valid1, in_ready1, mode_approx1, mode_sat1;
  logic       out_valid1, out_ready1, out_carry1, out_eof1, frame_done1;
  logic [7:0] in_a1, in_b1, out_sum1;
  logic [31:0] err_frame1;

  approx_add_stream #(
    .DATA_W(8), .APPROX_BITS(4), .FRAME_PIXELS(4), .CNT_W(2), .ERR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mode_approx(mode_approx), .mode_sat(mode_sat),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_eof(out_eof), .err_frame(err_frame),
    .frame_done(frame_done)
  );

  approx_add_stream #(
    .DATA_W(8), .APPROX_BITS(0), .FRAME_PIXELS(4), .CNT_W(2), .ERR_W(32)
  ) dut_exact (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .mode_approx(mode_approx1), .mode_sat(mode_sat1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_carry(out_carry1), .out_eof(out_eof1), .err_frame(err_frame1),
    .frame_done(frame_done1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat through an empty pipeline, checked at 2-cycle latency
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic ap,
                      input logic sat, input logic [7:0] exp_sum, input logic exp_c,
                      input logic exp_eof, input string tag);
    in_valid = 1'b1; in_a = a; in_b = b; mode_approx = ap; mode_sat = sat;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, "_sum"},   64'(out_sum),   64'(exp_sum));
    check({tag, "_carry"}, 64'(out_carry), 64'(exp_c));
    check({tag, "_eof"},   64'(out_eof),   64'(exp_eof));
    step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),   64'(1'b1));
    check({tag, "_out_valid"}, 64'(out_valid),  64'(1'b0));
    check({tag, "_out_sum"},   64'(out_sum),    64'(8'h00));
    check({tag, "_out_carry"}, 64'(out_carry),  64'(1'b0));
    check({tag, "_out_eof"},   64'(out_eof),    64'(1'b0));
    check({tag, "_err_frame"}, 64'(err_frame),  64'(32'd0));
    check({tag, "_frame_done"},64'(frame_done), 64'(1'b0));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; mode_approx = 1'b0; mode_sat = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; mode_approx1 = 1'b1; mode_sat1 = 1'b0; out_ready1 = 1'b1;
    #1;
    check_idle("rst_async");
    step(); step();
    rst = 1'b0;
    step();
    check_idle("rst_rel");

    // Arithmetic: one frame of four distinct beats, only the LOA one has error 1
    beat(8'h1F, 8'h01, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0, "loa_1f");
    beat(8'h1F, 8'h01, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, "exact_1f");
    beat(8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, "wrap_f0");
    beat(8'hF0, 8'h20, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, "sat_f0");
    check("f1_done", 64'(frame_done), 64'(1'b1));
    check("f1_err",  64'(err_frame),  64'(32'd1));
    step();
    check("f1_done_low", 64'(frame_done), 64'(1'b0));

    // Frame of four LOA 0x1F+0x01 beats: error 1 each
    for (int i = 0; i < 4; i++)
      beat(8'h1F, 8'h01, 1'b1, 1'b0, 8'h1F, 1'b0, (i == 3), "frame_loa");
    check("f2_done", 64'(frame_done), 64'(1'b1));
    check("f2_err",  64'(err_frame),  64'(32'd4));
    step();
    check("f2_done_once", 64'(frame_done), 64'(1'b0));

    // Start a new frame, then fill both stages and reset asynchronously
    beat(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "f3_b0");
    beat(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "f3_b1");
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h55; in_b = 8'h01; mode_approx = 1'b1; mode_sat = 1'b0;
    step(); step();
    check("full_in_ready",  64'(in_ready),  64'(1'b0));
    check("full_out_valid", 64'(out_valid), 64'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("mid_rst_in_ready",  64'(in_ready),  64'(1'b1));
    check("mid_rst_err_frame", 64'(err_frame), 64'(32'd0));
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Frame after reset: eof exactly on the 4th transfer; LOA over/under-estimates
    // 0x08+0x08 LOA -> 0x18 (exact 0x10, e=8); 0xFF+0xFF LOA -> 0x1FF (exact 0x1FE, e=1)
    beat(8'h08, 8'h08, 1'b1, 1'b0, 8'h18, 1'b0, 1'b0, "post_rst_b0");
    beat(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, "post_rst_b1");
    beat(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "post_rst_b2");
    beat(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, "post_rst_b3");
    check("f4_done", 64'(frame_done), 64'(1'b1));
    check("f4_err",  64'(err_frame),  64'(32'd9));
    step();

    // Back-pressure: 8 incrementing beats, out_ready low for the first 5 cycles
    begin
      int sent;
      int recv;
      logic acc;
      logic xf;
      sent = 0; recv = 0;
      mode_approx = 1'b0; mode_sat = 1'b0; in_b = 8'h00;
      for (int c = 0; c < 40 && recv < 8; c++) begin
        out_ready = (c >= 5);
        in_valid  = (sent < 8);
        in_a      = 8'(8'h10 + sent);
        #1;
        if (out_valid) check("stall_data", 64'(out_sum), 64'(8'h10 + recv));
        if (c == 4) begin
          check("stall_in_ready", 64'(in_ready), 64'(1'b0));
          check("stall_accepted", 64'(sent), 64'(2));
        end
        acc = in_valid && in_ready;
        xf  = out_valid && out_ready;
        if (acc) sent++;
        if (xf)  recv++;
        step();
      end
      in_valid = 1'b0;
      check("stall_recv_count", 64'(recv), 64'(8));
    end

    // Exact-only build: LOA requested but results must equal the exact sum
    begin
      logic [8:0] q[$];
      logic [8:0] exp_v;
      int sent;
      sent = 0;
      for (int c = 0; c < 1100 && (sent < 1000 || q.size() > 0); c++) begin
        in_valid1 = (sent < 1000);
        in_a1 = 8'($urandom);
        in_b1 = 8'($urandom);
        #1;
        if (out_valid1 && out_ready1) begin
          if (q.size() > 0) begin
            exp_v = q.pop_front();
            check("k0_sum", 64'({out_carry1, out_sum1}), 64'(exp_v));
          end else begin
            check("k0_unexpected_out", 64'(1'b1), 64'(1'b0));
          end
        end
        if (in_valid1 && in_ready1) begin
          q.push_back({1'b0, in_a1} + {1'b0, in_b1});
          sent++;
        end
        step();
      end
      in_valid1 = 1'b0;
      check("k0_sent", 64'(sent), 64'(1000));
      check("k0_drained", 64'(q.size()), 64'(0));
      check("k0_err_frame", 64'(err_frame1), 64'(32'd0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
